// File: rtl/alu_cmd_sequencer.sv
// Command front-end for the 4-bit ALU tile. It queues {op,a,b} commands in a FIFO, issues one at a time,
// and captures the registered ALU result into a valid/ready response with per-opcode flag cleanup.
module alu_cmd_sequencer #(
   parameter int DEPTH = 4,
   parameter int CNT_W = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [2:0]       cmd_op,
   input  logic [3:0]       cmd_a,
   input  logic [3:0]       cmd_b,
   output logic [7:0]       alu_ui_in,
   output logic [2:0]       alu_opcode,
   input  logic [7:0]       alu_result,
   input  logic             alu_carry,
   input  logic             alu_ovf,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [7:0]       rsp_result,
   output logic             rsp_carry,
   output logic             rsp_ovf,
   output logic             rsp_divz,
   output logic [2:0]       rsp_op,
   output logic [CNT_W-1:0] count,
   output logic             busy
);

   localparam int               PTR_W     = $clog2(DEPTH);
   localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
   localparam logic [2:0]       OP_ADD    = 3'd0;
   localparam logic [2:0]       OP_SUB    = 3'd1;
   localparam logic [2:0]       OP_DIV    = 3'd3;

   typedef struct packed {
      logic [2:0] op;
      logic [3:0] a;
      logic [3:0] b;
   } cmd_t;

   typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, HOLD} state_t;

   state_t           state;
   state_t           state_nxt;
   cmd_t             fifo_mem [DEPTH];
   cmd_t             head;
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             push;
   logic             pop;
   logic             empty;
   logic             head_addsub;

   assign empty       = (count == '0);
   assign cmd_ready   = (count < DEPTH_CNT);
   assign push        = cmd_valid && cmd_ready;
   assign pop         = (state == CAPTURE);
   assign head        = fifo_mem[rd_ptr];
   assign alu_ui_in   = empty ? 8'h00 : {head.a, head.b};
   assign alu_opcode  = empty ? 3'b000 : head.op;
   assign busy        = (state != IDLE) || !empty;
   assign head_addsub = (head.op == OP_ADD) || (head.op == OP_SUB);

   // NOTE: the storage array is deliberately not reset; pointers and count alone define which entries are live.
   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr] <= {cmd_op, cmd_a, cmd_b};
   end

   // NOTE: sequential state is written with <= only, so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // NOTE: state_nxt is defaulted first so no path through the case can infer a latch.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (!empty) state_nxt = ISSUE;
         ISSUE:   state_nxt = CAPTURE;
         CAPTURE: state_nxt = HOLD;
         HOLD:    if (rsp_ready) state_nxt = (!empty || push) ? ISSUE : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // The ALU leaves carry/ovf stale on non-arithmetic ops, so they are only passed through for ADD/SUB.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_valid  <= 1'b0;
         rsp_result <= 8'h00;
         rsp_carry  <= 1'b0;
         rsp_ovf    <= 1'b0;
         rsp_divz   <= 1'b0;
         rsp_op     <= 3'b000;
      end else if (state == CAPTURE) begin
         rsp_valid  <= 1'b1;
         rsp_result <= alu_result;
         rsp_carry  <= alu_carry && head_addsub;
         rsp_ovf    <= alu_ovf && head_addsub;
         rsp_divz   <= (head.op == OP_DIV) && (head.b == 4'h0);
         rsp_op     <= head.op;
      end else if (state == HOLD && rsp_ready) begin
         rsp_valid  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer; includes a registered 4-bit ALU model that holds
// stale carry/ovf on non-arithmetic ops, as the real tile does.
module tb_alu_cmd_sequencer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [2:0] cmd_op;
   logic [3:0] cmd_a;
   logic [3:0] cmd_b;
   logic [7:0] alu_ui_in;
   logic [2:0] alu_opcode;
   logic [7:0] alu_result;
   logic       alu_carry;
   logic       alu_ovf;
   logic       rsp_valid;
   logic       rsp_ready;
   logic [7:0] rsp_result;
   logic       rsp_carry;
   logic       rsp_ovf;
   logic       rsp_divz;
   logic [2:0] rsp_op;
   logic [2:0] count;
   logic       busy;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic [2:0] op;
      logic [7:0] res;
      logic       c;
      logic       v;
      logic       z;
   } exp_t;

   exp_t exp_q[$];

   always #5 clk = ~clk;

   alu_cmd_sequencer #(.DEPTH(4), .CNT_W(3)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_op     (cmd_op),
      .cmd_a      (cmd_a),
      .cmd_b      (cmd_b),
      .alu_ui_in  (alu_ui_in),
      .alu_opcode (alu_opcode),
      .alu_result (alu_result),
      .alu_carry  (alu_carry),
      .alu_ovf    (alu_ovf),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_result (rsp_result),
      .rsp_carry  (rsp_carry),
      .rsp_ovf    (rsp_ovf),
      .rsp_divz   (rsp_divz),
      .rsp_op     (rsp_op),
      .count      (count),
      .busy       (busy)
   );

   // ALU tile model
   logic [3:0] m_a;
   logic [3:0] m_b;
   logic [4:0] m_s;
   logic [7:0] m_res;
   logic       m_c;
   logic       m_v;

   always_comb begin
      m_a   = alu_ui_in[7:4];
      m_b   = alu_ui_in[3:0];
      m_s   = 5'd0;
      m_res = 8'h00;
      m_c   = alu_carry;
      m_v   = alu_ovf;
      case (alu_opcode)
         3'd0: begin
            m_s   = {1'b0, m_a} + {1'b0, m_b};
            m_res = {4'h0, m_s[3:0]};
            m_c   = m_s[4];
            m_v   = (m_a[3] == m_b[3]) && (m_s[3] != m_a[3]);
         end
         3'd1: begin
            m_s   = {1'b0, m_a} - {1'b0, m_b};
            m_res = {4'h0, m_s[3:0]};
            m_c   = ~m_s[4];
            m_v   = (m_a[3] != m_b[3]) && (m_s[3] != m_a[3]);
         end
         3'd2:    m_res = {4'h0, m_a} * {4'h0, m_b};
         3'd3:    m_res = (m_b == 4'h0) ? 8'h00 : {m_a % m_b, m_a / m_b};
         3'd4:    m_res = {4'h0, m_a & m_b};
         3'd5:    m_res = {4'h0, m_a | m_b};
         3'd6:    m_res = {4'h0, m_a ^ m_b};
         default: m_res = {4'h0, ~m_a};
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alu_result <= 8'h00;
         alu_carry  <= 1'b0;
         alu_ovf    <= 1'b0;
      end else begin
         alu_result <= m_res;
         alu_carry  <= m_c;
         alu_ovf    <= m_v;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic add_exp(input logic [2:0] op, input logic [7:0] res,
                          input logic c, input logic v, input logic z);
      exp_t e;
      e.op  = op;
      e.res = res;
      e.c   = c;
      e.v   = v;
      e.z   = z;
      exp_q.push_back(e);
   endtask

   // Called at a negedge; leaves the command presented for exactly one edge.
   task automatic send(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_a     = a;
      cmd_b     = b;
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   // Accept n responses with rsp_ready held high; optionally check the 3-cycle spacing.
   task automatic drain(input int n, input bit gap);
      int   got  = 0;
      int   cyc  = 0;
      int   last = 0;
      exp_t e;
      rsp_ready = 1'b1;
      while (got < n && cyc < 20 * n + 10) begin
         if (rsp_valid) begin
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               check("rsp_result", rsp_result, e.res);
               check("rsp_op",     rsp_op,     e.op);
               check("rsp_carry",  rsp_carry,  e.c);
               check("rsp_ovf",    rsp_ovf,    e.v);
               check("rsp_divz",   rsp_divz,   e.z);
            end else begin
               check("rsp_unexpected", 1, 0);
            end
            if (gap && got > 0) check("rsp_spacing", cyc - last, 3);
            last = cyc;
            got++;
         end
         @(negedge clk);
         cyc++;
      end
      rsp_ready = 1'b0;
      check("drain_count", got, n);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int acc;
      rst_n     = 1'b0;
      cmd_valid = 1'b0;
      cmd_op    = 3'd0;
      cmd_a     = 4'h0;
      cmd_b     = 4'h0;
      rsp_ready = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_count",     count,     0);
      check("rst_cmd_ready", cmd_ready, 1);
      check("rst_rsp_res",   rsp_result, 0);
      rst_n = 1'b1;
      @(negedge clk);
      check("idle_busy",   busy,       0);
      check("idle_ui_in",  alu_ui_in,  8'h00);
      check("idle_opcode", alu_opcode, 3'd0);

      // Latency of ADD 7+9 from an idle block; OR queued behind it sees a stale carry of 1.
      cmd_valid = 1'b1; cmd_op = 3'd0; cmd_a = 4'h7; cmd_b = 4'h9;
      check("t1_ready", cmd_ready, 1);
      @(negedge clk);
      cmd_op = 3'd5; cmd_a = 4'hF; cmd_b = 4'h0;
      check("t1_e0_count", count, 1);
      check("t1_e0_valid", rsp_valid, 0);
      check("t1_e0_ui_in", alu_ui_in, 8'h79);
      check("t1_e0_busy",  busy, 1);
      @(negedge clk);
      cmd_valid = 1'b0;
      check("t1_e1_valid", rsp_valid, 0);
      check("t1_e1_count", count, 2);
      @(negedge clk);
      check("t1_e2_valid", rsp_valid, 0);
      check("t1_e2_opcode", alu_opcode, 3'd0);
      @(negedge clk);
      check("t1_e3_valid", rsp_valid, 1);
      check("t1_e3_count", count, 1);
      add_exp(3'd0, 8'h00, 1'b1, 1'b0, 1'b0);
      add_exp(3'd5, 8'h0F, 1'b0, 1'b0, 1'b0);
      drain(2, 1'b1);

      // SUB with borrow, MUL wide result
      send(3'd1, 4'h3, 4'h5);
      send(3'd2, 4'hF, 4'hF);
      add_exp(3'd1, 8'h0E, 1'b0, 1'b0, 1'b0);
      add_exp(3'd2, 8'hE1, 1'b0, 1'b0, 1'b0);
      drain(2, 1'b1);

      // Signed overflow on ADD, then XOR must mask the stale ovf
      send(3'd0, 4'h7, 4'h1);
      send(3'd6, 4'h5, 4'h3);
      add_exp(3'd0, 8'h08, 1'b0, 1'b1, 1'b0);
      add_exp(3'd6, 8'h06, 1'b0, 1'b0, 1'b0);
      drain(2, 1'b1);

      // Division and the divide-by-zero flag, which applies to DIV only
      send(3'd3, 4'd13, 4'd4);
      send(3'd3, 4'd5, 4'd0);
      send(3'd4, 4'd5, 4'd0);
      add_exp(3'd3, 8'h13, 1'b0, 1'b0, 1'b0);
      add_exp(3'd3, 8'h00, 1'b0, 1'b0, 1'b1);
      add_exp(3'd4, 8'h00, 1'b0, 1'b0, 1'b0);
      drain(3, 1'b1);

      // Six back-to-back commands with the consumer stalled
      acc = 0;
      for (int i = 0; i < 6; i++) begin
         cmd_valid = 1'b1;
         case (i)
            0:       begin cmd_op = 3'd0; cmd_a = 4'h1; cmd_b = 4'h2; end
            1:       begin cmd_op = 3'd1; cmd_a = 4'h9; cmd_b = 4'h4; end
            2:       begin cmd_op = 3'd5; cmd_a = 4'hA; cmd_b = 4'h5; end
            3:       begin cmd_op = 3'd7; cmd_a = 4'h3; cmd_b = 4'h0; end
            4:       begin cmd_op = 3'd2; cmd_a = 4'h3; cmd_b = 4'h4; end
            default: begin cmd_op = 3'd4; cmd_a = 4'hF; cmd_b = 4'h1; end
         endcase
         if (i == 5) check("t4_sixth_ready", cmd_ready, 0);
         if (cmd_ready) acc++;
         @(negedge clk);
      end
      cmd_valid = 1'b0;
      check("t4_accepted",  acc, 5);
      check("t4_cmd_ready", cmd_ready, 0);
      check("t4_count",     count, 4);
      check("t4_held",      rsp_valid, 1);
      add_exp(3'd0, 8'h03, 1'b0, 1'b0, 1'b0);
      add_exp(3'd1, 8'h05, 1'b1, 1'b1, 1'b0);
      add_exp(3'd5, 8'h0F, 1'b0, 1'b0, 1'b0);
      add_exp(3'd7, 8'h0C, 1'b0, 1'b0, 1'b0);
      add_exp(3'd2, 8'h0C, 1'b0, 1'b0, 1'b0);
      drain(5, 1'b1);

      // Full FIFO: a push offered in the pop cycle is refused, count goes 4->3
      for (int i = 0; i < 5; i++) begin
         cmd_valid = 1'b1; cmd_op = 3'd0; cmd_a = 4'(i + 2); cmd_b = 4'(i + 2);
         @(negedge clk);
      end
      cmd_valid = 1'b0;
      check("t5_fill_count", count, 4);
      check("t5_first_res",  rsp_result, 8'h04);
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      check("t5_issue_valid", rsp_valid, 0);
      check("t5_issue_count", count, 4);
      cmd_valid = 1'b1; cmd_op = 3'd0; cmd_a = 4'h7; cmd_b = 4'h7;
      @(negedge clk);
      check("t5_cap_count", count, 4);
      check("t5_cap_ready", cmd_ready, 0);
      @(negedge clk);
      check("t5_pop_count", count, 3);
      check("t5_pop_ready", cmd_ready, 1);
      @(negedge clk);
      cmd_valid = 1'b0;
      check("t5_push_count", count, 4);
      add_exp(3'd0, 8'h06, 1'b0, 1'b0, 1'b0);
      add_exp(3'd0, 8'h08, 1'b0, 1'b1, 1'b0);
      add_exp(3'd0, 8'h0A, 1'b0, 1'b1, 1'b0);
      add_exp(3'd0, 8'h0C, 1'b0, 1'b1, 1'b0);
      add_exp(3'd0, 8'h0E, 1'b0, 1'b1, 1'b0);
      drain(5, 1'b1);

      // Asynchronous reset in CAPTURE discards the in-flight command
      send(3'd0, 4'h2, 4'h3);
      @(negedge clk);
      @(negedge clk);
      check("t6_busy", busy, 1);
      rst_n = 1'b0;
      #1;
      check("t6_rsp_valid", rsp_valid, 0);
      check("t6_count",     count, 0);
      check("t6_cmd_ready", cmd_ready, 1);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("t6_post_valid", rsp_valid, 0);
      check("t6_post_busy",  busy, 0);
      send(3'd0, 4'h1, 4'h1);
      add_exp(3'd0, 8'h02, 1'b0, 1'b0, 1'b0);
      drain(1, 1'b0);
      check("leftover_expected", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
